// File: rtl/dice_pkg.sv
// Shared definitions for the 3x3 dice LED display: pattern width, the
// standard dice table and a table lookup used by encoder and decoder.
package dice_pkg;

  localparam int LED_W = 9;

  // Packing order, MSB first: {L11,L21,L31,L12,L22,L32,L13,L23,L33}
  localparam logic [0:7][LED_W-1:0] DICE_PATTERNS = '{
    9'b000_000_000,
    9'b000_010_000,
    9'b100_000_001,
    9'b100_010_001,
    9'b101_000_101,
    9'b101_010_101,
    9'b101_101_101,
    9'b111_101_111
  };

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Returns {hit, value}; value is 0 when the pattern is not in the table.
  function automatic logic [3:0] pattern_to_value(input logic [LED_W-1:0] p);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (p == DICE_PATTERNS[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_debounce.sv
// Two-flop synchroniser on the LED lines followed by a stability filter that
// strobes once per newly settled pattern (ignoring returns to the last one).
module pattern_debounce
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] lines,
  output logic [LED_W-1:0] cand,
  output logic             stable_event
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [LED_W-1:0] sync1;
  logic [LED_W-1:0] sync2;
  logic [LED_W-1:0] last;
  logic [7:0]       cnt;

  // Combinational so the output stage captures the result on the event edge.
  assign stable_event = (sync2 == cand) && (cnt == STABLE_MAX) && (cand != last);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      last  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= lines;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= 8'd1;
      end else if (cnt != STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (stable_event) last <= cand;
    end
  end

endmodule

// File: rtl/dice_decoder.sv
// Receive side of the dice LED interface: debounces the nine lines, decodes
// each newly settled pattern and offers it over a valid/ready output.
module dice_decoder
  import dice_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       L11,
  input  logic       L12,
  input  logic       L13,
  input  logic       L21,
  input  logic       L22,
  input  logic       L23,
  input  logic       L31,
  input  logic       L32,
  input  logic       L33,
  input  logic       OutReady,
  output logic       OutValid,
  output logic [2:0] DiceValue,
  output logic       PatternError,
  output logic       Overrun
);

  // Handshake: a result transfers on an edge with OutValid=1 and OutReady=1;
  // while OutValid=1 and OutReady=0 the result is held unchanged, and a new
  // event arriving then is dropped and sets the sticky Overrun flag.

  logic [LED_W-1:0] lines;
  logic [LED_W-1:0] cand;
  logic             stable_event;
  logic [3:0]       decoded;

  out_state_t state, state_nxt;
  logic [2:0] value_q, value_nxt;
  logic       error_q, error_nxt;
  logic       overrun_q, overrun_nxt;

  assign lines = {L11, L21, L31, L12, L22, L32, L13, L23, L33};

  pattern_debounce #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk          (Clock),
    .rst          (Reset),
    .lines        (lines),
    .cand         (cand),
    .stable_event (stable_event)
  );

  assign decoded = pattern_to_value(cand);

  always_comb begin
    state_nxt   = state;
    value_nxt   = value_q;
    error_nxt   = error_q;
    overrun_nxt = overrun_q;
    unique case (state)
      OUT_EMPTY: begin
        if (stable_event) begin
          state_nxt = OUT_FULL;
          value_nxt = decoded[2:0];
          error_nxt = ~decoded[3];
        end
      end
      OUT_FULL: begin
        if (stable_event && OutReady) begin
          value_nxt = decoded[2:0];
          error_nxt = ~decoded[3];
        end else if (stable_event) begin
          overrun_nxt = 1'b1;
        end else if (OutReady) begin
          state_nxt = OUT_EMPTY;
        end
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= OUT_EMPTY;
      value_q   <= 3'd0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      value_q   <= value_nxt;
      error_q   <= error_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign OutValid     = (state == OUT_FULL);
  assign DiceValue    = value_q;
  assign PatternError = error_q;
  assign Overrun      = overrun_q;

endmodule

// File: doc/dice_decoder.md
Name: dice_decoder

Overview:
- Receive side of the 3x3 dice LED display interface: takes the nine LED drive lines and recovers the 3-bit dice value.
- Synchronises the lines, requires the pattern to be stable for STABLE_CYCLES, then decodes it against the standard dice table.
- Reports each new stable pattern once over a valid/ready channel, flagging patterns not in the table.
- Used for loop-back checking of the LED encoder path and for reading an external dice display.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted; legal range 1..255.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
L11, L12, L13, L21, L22, L23, L31, L32, L33  input  1 each  LED lines (Lrc: row r, column c); asynchronous to Clock
OutReady  input  1  consumer accepts current result
OutValid  output  1  result pending
DiceValue  output  3  decoded value; 0 when PatternError=1
PatternError  output  1  accepted pattern matched no table entry
Overrun  output  1  sticky; a result was dropped because the previous one was not consumed

Behaviour:
- Reset: on an edge with Reset=1, all state clears together, including mid-settle or mid-handshake. After that edge, every output is 0, both synchroniser stages are 0, and the candidate and last-reported patterns are 9'h000.
- Packing: P = {L11,L21,L31,L12,L22,L32,L13,L23,L33}, MSB first.
- Decode table for P:
  - 0 = 000_000_000
  - 1 = 000_010_000
  - 2 = 100_000_001
  - 3 = 100_010_001
  - 4 = 101_000_101
  - 5 = 101_010_101
  - 6 = 101_101_101
  - 7 = 111_101_111
  - Any other value is an error pattern.
- Synchroniser: two flops per line. S is the second-stage output.
- Stability filter (every edge):
  - If S != cand: cand <= S, cnt <= 1.
  - Otherwise: cnt increments and saturates at STABLE_CYCLES.
- Event: fires on an edge where S == cand, cnt == STABLE_CYCLES and cand != last.
  - Same edge: last <= cand.
  - Event payload: DiceValue/PatternError from decoding cand.
- Latency: let E0 be the edge on which a new pattern is first captured by stage 1. If the pattern holds, the event edge is E0 + STABLE_CYCLES + 2, and OutValid is high after that edge.
- Glitch rejection: a pattern held for fewer than STABLE_CYCLES samples of S produces no event. A return to the last-reported pattern produces no event.
- All-off after reset produces no event, because last is reset to 9'h000.
- Handshake:
  - OutValid, DiceValue and PatternError hold stable while OutValid=1 and OutReady=0.
  - Transfer occurs on an edge with OutValid=1 and OutReady=1. OutValid then clears, unless an event occurs on the same edge: the new result loads and OutValid stays 1 (back-to-back).
  - Event while OutValid=1 and OutReady=0: the new result is dropped, the held result is unchanged, and Overrun <= 1. Overrun clears only on Reset. last still updates.
  - OutReady while OutValid=0 has no effect.
- FSM in the output stage:
  - EMPTY -> FULL on event.
  - FULL -> EMPTY on transfer with no event.
  - FULL -> FULL on transfer with an event, or on an event without transfer (drop + Overrun).

Decomposition:
- Package dice_pkg:
  - LED_W = 9.
  - DICE_PATTERNS: constant array [0:7] of 9-bit patterns, in the packing order above.
  - Function pattern_to_value returning {hit, value}.
  - The encoder shares this package.
- Sub-module pattern_debounce: synchroniser plus stability filter.
  - Parameter STABLE_CYCLES.
  - Outputs cand and a one-cycle event strobe.
- dice_decoder contains the decode and the output handshake FSM.

Test Plan:
- STABLE_CYCLES=4, OutReady=1, lines driven to 100_010_001 at E0 -> OutValid=1, DiceValue=3, PatternError=0 after edge E0+6; OutValid low one cycle later.
- Pattern 111_101_111 held 3 sampled cycles, then back to 000_000_000 -> OutValid never asserts.
- Pattern 110_000_000 held 10 cycles -> one result: PatternError=1, DiceValue=0. Holding longer gives no repeat.
- OutReady=0; report value 5, then stable value 6 -> OutValid holds DiceValue=5, Overrun=1. OutReady=1 -> transfer 5, then OutValid=0; 6 is lost.
- Value 2 pending with OutReady=0. Raise OutReady on the exact edge a value-4 event fires -> OutValid stays 1, DiceValue=4, Overrun=0.
- Reset=1 for one edge while OutValid=1 and mid-settle -> all outputs 0 after that edge; a pattern already stable on the lines re-reports STABLE_CYCLES+2 edges after Reset falls.
